traffic_controller: RTL



---
 rtl/traffic_pkg.sv | 47 ++++
 rtl/traffic_lane.sv | 67 ++++++
 rtl/traffic_controller.sv | 115 +++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared constants and lane-geometry helpers for the traffic controller.
package traffic_pkg;

  localparam int unsigned GRID_COLS = 20;
  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned X_W       = 5;
  localparam int unsigned Y_W       = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned LVL_W     = 2;

  // Grid row occupied by each lane; rows 0-3, 8, 9 and 14 stay car-free.
  function automatic logic [Y_W-1:0] lane_row(input int unsigned lane);
    case (lane)
      0:       return Y_W'(13);
      1:       return Y_W'(12);
      2:       return Y_W'(11);
      3:       return Y_W'(10);
      4:       return Y_W'(7);
      5:       return Y_W'(6);
      6:       return Y_W'(5);
      default: return Y_W'(4);
    endcase
  endfunction

  // Level-0 step period in game ticks, indexed by lane mod 4.
  function automatic logic [CNT_W-1:0] base_period(input int unsigned idx);
    case (idx % 4)
      0:       return CNT_W'(4);
      1:       return CNT_W'(6);
      2:       return CNT_W'(8);
      default: return CNT_W'(10);
    endcase
  endfunction

  // Odd lanes move right (x+1), even lanes move left (x-1).
  function automatic logic lane_moves_up(input int unsigned lane);
    return lane[0];
  endfunction

  // Starting column: car A at 3L, car B half a grid further along.
  function automatic logic [X_W-1:0] init_x(input int unsigned lane, input logic car_b);
    int unsigned v;
    v = 3 * lane + (car_b ? 10 : 0);
    return X_W'(v % GRID_COLS);
  endfunction

endpackage

// File: rtl/traffic_lane.sv
// One traffic lane: step-period counter plus the column of its two cars.
module traffic_lane
  import traffic_pkg::*;
#(
  parameter int unsigned LANE = 0
) (
  input  logic             clk,
  input  logic             reset_cars,
  input  logic             tick,
  input  logic             enable,
  input  logic [LVL_W-1:0] level,
  output logic [X_W-1:0]   xa,
  output logic [X_W-1:0]   xb
);

  localparam logic [X_W-1:0]   XA_INIT = init_x(LANE, 1'b0);
  localparam logic [X_W-1:0]   XB_INIT = init_x(LANE, 1'b1);
  localparam logic [CNT_W-1:0] BASE    = base_period(LANE);
  localparam logic             MOVE_UP = lane_moves_up(LANE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   xa_q, xa_d;
  logic [X_W-1:0]   xb_q, xb_d;
  logic [CNT_W-1:0] period_c;
  logic [CNT_W-1:0] last_c;

  // One column step in this lane's direction with wrap at the grid edge.
  function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x);
    if (MOVE_UP) return (x == X_W'(GRID_COLS - 1)) ? '0 : x + X_W'(1);
    else         return (x == '0) ? X_W'(GRID_COLS - 1) : x - X_W'(1);
  endfunction

  // Next counter and positions; >= keeps a mid-count period shrink safe.
  always_comb begin
    cnt_d    = cnt_q;
    xa_d     = xa_q;
    xb_d     = xb_q;
    period_c = (BASE > CNT_W'(level)) ? BASE - CNT_W'(level) : CNT_W'(1);
    last_c   = period_c - CNT_W'(1);
    if (tick && enable) begin
      if (cnt_q >= last_c) begin
        cnt_d = '0;
        xa_d  = step_x(xa_q);
        xb_d  = step_x(xb_q);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Lane state registers with synchronous reset to the starting layout.
  always_ff @(posedge clk) begin
    if (reset_cars) begin
      cnt_q <= '0;
      xa_q  <= XA_INIT;
      xb_q  <= XB_INIT;
    end else begin
      cnt_q <= cnt_d;
      xa_q  <= xa_d;
      xb_q  <= xb_d;
    end
  end

  assign xa = xa_q;
  assign xb = xb_q;

endmodule

// File: rtl/traffic_controller.sv
// Traffic controller: game-tick prescaler, freeze/level control and 8 lanes.
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 1250000,
  parameter int unsigned FREEZE_TICKS = 10,
  parameter int unsigned MAX_LEVEL    = 3
) (
  input  logic       clk,
  input  logic       reset_cars,
  input  logic       frog_at_top,
  input  logic       collision_detected,
  input  logic [1:0] lives,
  output logic [4:0] car1_x,  output logic [3:0] car1_y,
  output logic [4:0] car2_x,  output logic [3:0] car2_y,
  output logic [4:0] car3_x,  output logic [3:0] car3_y,
  output logic [4:0] car4_x,  output logic [3:0] car4_y,
  output logic [4:0] car5_x,  output logic [3:0] car5_y,
  output logic [4:0] car6_x,  output logic [3:0] car6_y,
  output logic [4:0] car7_x,  output logic [3:0] car7_y,
  output logic [4:0] car8_x,  output logic [3:0] car8_y,
  output logic [4:0] car9_x,  output logic [3:0] car9_y,
  output logic [4:0] car10_x, output logic [3:0] car10_y,
  output logic [4:0] car11_x, output logic [3:0] car11_y,
  output logic [4:0] car12_x, output logic [3:0] car12_y,
  output logic [4:0] car13_x, output logic [3:0] car13_y,
  output logic [4:0] car14_x, output logic [3:0] car14_y,
  output logic [4:0] car15_x, output logic [3:0] car15_y,
  output logic [4:0] car16_x, output logic [3:0] car16_y,
  output logic [1:0] level
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FRZ_W = (FREEZE_TICKS > 0) ? $clog2(FREEZE_TICKS + 1) : 1;

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [FRZ_W-1:0] freeze_q, freeze_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             frog_q, frog_d;
  logic             tick_c;
  logic             enable_c;
  logic             frog_rise_c;

  logic [X_W-1:0] lane_xa [NUM_LANES];
  logic [X_W-1:0] lane_xb [NUM_LANES];

  // Tick generation, collision freeze and level-up on frog reaching row 0.
  always_comb begin
    presc_d     = presc_q + PRE_W'(1);
    freeze_d    = freeze_q;
    level_d     = level_q;
    frog_d      = frog_at_top;
    tick_c      = (presc_q == PRE_W'(TICK_DIV - 1));
    enable_c    = (lives != 2'd0) && (freeze_q == '0);
    frog_rise_c = frog_at_top && !frog_q;
    if (tick_c) presc_d = '0;
    if (collision_detected) begin
      freeze_d = FRZ_W'(FREEZE_TICKS);
    end else if (tick_c && (freeze_q != '0)) begin
      freeze_d = freeze_q - FRZ_W'(1);
    end
    // Level is held once the game is over.
    if (frog_rise_c && (lives != 2'd0) && (level_q < LVL_W'(MAX_LEVEL))) begin
      level_d = level_q + LVL_W'(1);
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_cars) begin
      presc_q  <= '0;
      freeze_q <= '0;
      level_q  <= '0;
      frog_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      freeze_q <= freeze_d;
      level_q  <= level_d;
      frog_q   <= frog_d;
    end
  end

  // Lanes see the registered level, so a level-up on a tick uses the old level.
  for (genvar l = 0; l < int'(NUM_LANES); l++) begin : g_lane
    traffic_lane #(.LANE(l)) u_lane (
      .clk        (clk),
      .reset_cars (reset_cars),
      .tick       (tick_c),
      .enable     (enable_c),
      .level      (level_q),
      .xa         (lane_xa[l]),
      .xb         (lane_xb[l])
    );
  end

  assign level = level_q;

  assign car1_x  = lane_xa[0]; assign car1_y  = lane_row(0);
  assign car2_x  = lane_xb[0]; assign car2_y  = lane_row(0);
  assign car3_x  = lane_xa[1]; assign car3_y  = lane_row(1);
  assign car4_x  = lane_xb[1]; assign car4_y  = lane_row(1);
  assign car5_x  = lane_xa[2]; assign car5_y  = lane_row(2);
  assign car6_x  = lane_xb[2]; assign car6_y  = lane_row(2);
  assign car7_x  = lane_xa[3]; assign car7_y  = lane_row(3);
  assign car8_x  = lane_xb[3]; assign car8_y  = lane_row(3);
  assign car9_x  = lane_xa[4]; assign car9_y  = lane_row(4);
  assign car10_x = lane_xb[4]; assign car10_y = lane_row(4);
  assign car11_x = lane_xa[5]; assign car11_y = lane_row(5);
  assign car12_x = lane_xb[5]; assign car12_y = lane_row(5);
  assign car13_x = lane_xa[6]; assign car13_y = lane_row(6);
  assign car14_x = lane_xb[6]; assign car14_y = lane_row(6);
  assign car15_x = lane_xa[7]; assign car15_y = lane_row(7);
  assign car16_x = lane_xb[7]; assign car16_y = lane_row(7);

endmodule
